// File: rtl/aqp_esp_spi_phy.sv
// aqp_esp_spi_phy: ESP SPI mode-0 slave PHY; pins are synchronized into clk and framed into bytes.
// SYNC_STAGES must be at least 2.
module aqp_esp_spi_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       esp_ssel_n,
    input  logic       esp_sclk,
    input  logic       esp_mosi,
    output logic       esp_miso,
    output logic       msg_start,
    output logic       msg_end,
    output logic [7:0] rxdata,
    output logic       rxdata_valid,
    input  logic [7:0] txdata,
    output logic       txdata_ack
);
    logic [SYNC_STAGES-1:0] ssel_q, sclk_q, mosi_q;
    logic ssel_h_q, sclk_h_q;
    logic ssel_s, sclk_s, mosi_s;
    logic ssel_fall, ssel_rise, sclk_rise, sclk_fall;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, rxdata_q, rxdata_d;
    logic start_q, start_d, end_q, end_d, valid_q, valid_d, ack_q, ack_d;

    // Idle preload keeps a quiet bus from looking like an edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssel_q   <= '1;
            sclk_q   <= '0;
            mosi_q   <= '0;
            ssel_h_q <= 1'b1;
            sclk_h_q <= 1'b0;
        end else begin
            ssel_q   <= {ssel_q[SYNC_STAGES-2:0], esp_ssel_n};
            sclk_q   <= {sclk_q[SYNC_STAGES-2:0], esp_sclk};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], esp_mosi};
            ssel_h_q <= ssel_q[SYNC_STAGES-1];
            sclk_h_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign ssel_s    = ssel_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign ssel_fall = ssel_h_q & ~ssel_s;
    assign ssel_rise = ~ssel_h_q & ssel_s;
    assign sclk_rise = ~sclk_h_q & sclk_s;
    assign sclk_fall = sclk_h_q & ~sclk_s;

    // A deselect edge has ssel_s high, so it already blocks any coincident shift.
    always_comb begin
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        rxdata_d = rxdata_q;
        start_d  = ssel_fall;
        end_d    = ssel_rise;
        valid_d  = 1'b0;
        ack_d    = 1'b0;
        if (ssel_fall) begin
            cnt_d = 3'd0;
            rx_d  = 8'h00;
            tx_d  = txdata;
        end else if (!ssel_s && sclk_rise) begin
            rx_d  = {rx_q[6:0], mosi_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                rxdata_d = {rx_q[6:0], mosi_s};
                valid_d  = 1'b1;
                tx_d     = txdata;
                ack_d    = 1'b1;
            end
        end else if (!ssel_s && sclk_fall && cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 3'd0;
            rx_q     <= 8'h00;
            tx_q     <= 8'h00;
            rxdata_q <= 8'h00;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            valid_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            rxdata_q <= rxdata_d;
            start_q  <= start_d;
            end_q    <= end_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
        end
    end

    assign esp_miso     = ~ssel_s & tx_q[7];
    assign msg_start    = start_q;
    assign msg_end      = end_q;
    assign rxdata       = rxdata_q;
    assign rxdata_valid = valid_q;
    assign txdata_ack   = ack_q;
endmodule

// File: tb/tb_aqp_esp_spi_phy.sv
// tb_aqp_esp_spi_phy: directed and randomized SPI messages checked against a byte-level model.
module tb_aqp_esp_spi_phy;
    logic clk = 1'b0, reset = 1'b1, ssel_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic [7:0] txd = 8'h00;
    logic miso, ms, me, rv, ta;
    logic [7:0] rxd;
    int cyc = 0, pass = 0, fail = 0, total = 0, last_rise = 0;
    int n_start = 0, n_end = 0, n_valid = 0, n_ack = 0;
    int bs, be, bv, ba, br;
    logic [7:0] rxq[$];
    int rxcyc[$];
    int rises[$];
    bit consec = 1'b0;
    logic [3:0] prev = 4'h0;

    aqp_esp_spi_phy #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .esp_ssel_n(ssel_n), .esp_sclk(sclk), .esp_mosi(mosi),
        .esp_miso(miso), .msg_start(ms), .msg_end(me), .rxdata(rxd), .rxdata_valid(rv),
        .txdata(txd), .txdata_ack(ta)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ms === 1'b1) n_start++;
        if (me === 1'b1) n_end++;
        if (ta === 1'b1) n_ack++;
        if (rv === 1'b1) begin
            n_valid++;
            rxq.push_back(rxd);
            rxcyc.push_back(cyc);
        end
        if (|({ms, me, rv, ta} & prev)) consec = 1'b1;
        prev = {ms, me, rv, ta};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        bs = n_start; be = n_end; bv = n_valid; ba = n_ack; br = rxq.size();
        rises.delete();
    endtask

    task automatic sel();
        ssel_n = 1'b0;
        clks(6);
    endtask

    task automatic desel();
        clks(4);
        ssel_n = 1'b1;
        clks(6);
    endtask

    // ESP side: change MOSI while SCLK is low, sample MISO just before the rising edge.
    task automatic sbit(input logic b, output logic m);
        mosi = b;
        clks(4);
        m = miso;
        sclk = 1'b1;
        last_rise = cyc;
        clks(4);
        sclk = 1'b0;
    endtask

    task automatic sbyte(input logic [7:0] d, input logic [7:0] nxt, output logic [7:0] m);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            sbit(d[i], b);
            m[i] = b;
            if (i == 7) txd = nxt;
        end
        rises.push_back(last_rise);
    endtask

    initial begin
        logic b;
        logic [7:0] m, m0, m1;
        logic [7:0] d[4];
        logic [7:0] tx[4];
        int nb, pb;
        clks(3);
        chk("rst_rxdata", rxd, 8'h00);
        chk("rst_miso", miso, 0);
        chk("rst_pulses", {ms, me, rv, ta}, 0);
        reset = 1'b0;
        clks(4);

        mark();
        repeat (10) begin
            sclk = 1'b1; clks(3);
            sclk = 1'b0; mosi = ~mosi; clks(3);
        end
        mosi = 1'b0;
        chk("idle_pulses", (n_start - bs) + (n_end - be) + (n_valid - bv) + (n_ack - ba), 0);
        chk("idle_miso", miso, 0);

        mark();
        txd = 8'h5A;
        sel();
        sbyte(8'hA5, 8'h00, m);
        desel();
        chk("a5_start", n_start - bs, 1);
        chk("a5_valid", n_valid - bv, 1);
        chk("a5_ack", n_ack - ba, 1);
        chk("a5_end", n_end - be, 1);
        chk("a5_rx", rxq[br], 8'hA5);
        chk("a5_miso", m, 8'h5A);

        mark();
        txd = 8'h3C;
        sel();
        sbyte(8'h11, 8'hC3, m0);
        sbyte(8'h22, 8'h00, m1);
        desel();
        chk("tx_byte0", m0, 8'h3C);
        chk("tx_byte1", m1, 8'hC3);
        chk("tx_ack", n_ack - ba, 2);
        chk("tx_valid", n_valid - bv, 2);

        mark();
        sel();
        repeat (5) sbit(1'b1, b);
        desel();
        chk("part_end", n_end - be, 1);
        chk("part_valid", n_valid - bv, 0);
        mark();
        sel();
        sbyte(8'h0F, 8'h00, m);
        desel();
        chk("part_next_valid", n_valid - bv, 1);
        chk("part_next_rx", rxq[br], 8'h0F);

        mark();
        txd = 8'hFF;
        sel();
        repeat (4) sbit(1'b1, b);
        reset = 1'b1;
        clks(1);
        chk("mid_rst_rxdata", rxd, 8'h00);
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_pulses", {ms, me, rv, ta}, 0);
        clks(2);
        reset = 1'b0;
        repeat (4) sbit(1'b0, b);
        desel();
        chk("mid_rst_no_valid", n_valid - bv, 0);
        mark();
        sel();
        sbyte(8'hC6, 8'h00, m);
        desel();
        chk("reselect_valid", n_valid - bv, 1);
        chk("reselect_rx", rxq[br], 8'hC6);

        mark();
        sel();
        sbyte(8'h20, 8'h00, m);
        sbyte(8'h00, 8'h00, m);
        sbyte(8'h80, 8'h00, m);
        desel();
        chk("burst_count", n_valid - bv, 3);
        d[0] = 8'h20; d[1] = 8'h00; d[2] = 8'h80;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("burst_rx%0d", i), rxq[br+i], d[i]);
            chk($sformatf("burst_lat%0d", i), rxcyc[br+i] - rises[i], 3);
        end

        for (int t = 0; t < 6; t++) begin
            nb = $urandom_range(1, 3);
            pb = $urandom_range(0, 7);
            for (int k = 0; k < 4; k++) begin
                d[k] = 8'($urandom);
                tx[k] = 8'($urandom);
            end
            mark();
            txd = tx[0];
            sel();
            for (int k = 0; k < nb; k++) begin
                sbyte(d[k], tx[k+1], m);
                chk($sformatf("rnd%0d_miso%0d", t, k), m, tx[k]);
            end
            repeat (pb) sbit(1'($urandom), b);
            desel();
            chk($sformatf("rnd%0d_valid", t), n_valid - bv, nb);
            chk($sformatf("rnd%0d_ack", t), n_ack - ba, nb);
            chk($sformatf("rnd%0d_start", t), n_start - bs, 1);
            chk($sformatf("rnd%0d_end", t), n_end - be, 1);
            for (int k = 0; k < nb; k++)
                chk($sformatf("rnd%0d_rx%0d", t, k), rxq[br+k], d[k]);
        end

        chk("no_back_to_back_pulses", consec, 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/aqp_esp_spi_phy.md
AQP_ESP_SPI_PHY -- requirements
Module: aqp_esp_spi_phy

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per pin input (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port esp_ssel_n  input  1  ESP chip select, active low, asynchronous to clk.
REQ-005 SHALL have port esp_sclk  input  1  ESP SPI clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port esp_mosi  input  1  ESP data to FPGA, MSB first.
REQ-007 SHALL have port esp_miso  output  1  FPGA data to ESP, MSB first.
REQ-008 SHALL have port msg_start  output  1  one-cycle pulse, selection begins.
REQ-009 SHALL have port msg_end  output  1  one-cycle pulse, selection ends.
REQ-010 SHALL have port rxdata  output  8  last complete received byte.
REQ-011 SHALL have port rxdata_valid  output  1  one-cycle pulse, rxdata updated.
REQ-012 SHALL have port txdata  input  8  next byte to transmit, sampled at byte boundaries.
REQ-013 SHALL have port txdata_ack  output  1  one-cycle pulse, txdata captured into transmit shifter.

Function
REQ-014 SHALL pass esp_ssel_n, esp_sclk and esp_mosi each through SYNC_STAGES flops plus one history flop; all edge detection uses the synchronized signals only.
REQ-015 SHALL pulse msg_start for one cycle on a detected synchronized ssel_n falling edge, and msg_end for one cycle on a detected rising edge.
REQ-016 On msg_start, SHALL clear the 3-bit bit counter, clear the receive shifter, and load txdata into the 8-bit transmit shifter without pulsing txdata_ack.
REQ-017 While selected, on each detected sclk rising edge, SHALL shift the synchronized mosi into receive shifter bit 0 and increment the bit counter modulo 8.
REQ-018 When the counter wraps 7->0, SHALL update rxdata with the completed byte and pulse rxdata_valid in the same cycle.
REQ-019 In that same cycle, SHALL load txdata into the transmit shifter and pulse txdata_ack.
REQ-020 While selected, on each detected sclk falling edge with counter != 0, SHALL shift the transmit shifter left by one.
REQ-021 A falling edge with counter == 0 SHALL NOT shift, so that bit 7 of a freshly loaded byte is held for the full first bit period.
REQ-022 SHALL drive esp_miso from transmit shifter bit 7 while synchronized ssel_n is low, and 0 otherwise.
REQ-023 SHALL ignore sclk edges while deselected.
REQ-024 If msg_end coincides with a sclk rising edge, msg_end SHALL take priority: no shift and no rxdata_valid. A partial byte at msg_end SHALL be discarded.
REQ-025 Latency SHALL be SYNC_STAGES+1 clk cycles from a pin edge to the corresponding pulse; correct operation is guaranteed for clk frequency >= 8x sclk frequency.
REQ-026 msg_start, msg_end, rxdata_valid and txdata_ack SHALL never be high for two consecutive cycles.

Reset
REQ-027 Reset SHALL asynchronously force all outputs low: msg_start, msg_end, rxdata_valid, txdata_ack = 0; rxdata = 8'h00; esp_miso = 0.
REQ-028 Reset SHALL set the bit counter and both shifters to 0, and preload the synchronizer and history flops of ssel_n and sclk to the idle values 1 and 0.
REQ-029 After reset deasserts mid-message, the block SHALL stay idle (no rxdata_valid) until the next ssel_n falling edge.

Verification
REQ-030 SHALL verify: select, clock in 8'hA5 MSB first -> msg_start once, rxdata_valid once with rxdata = 8'hA5, txdata_ack once.
REQ-031 SHALL verify: txdata = 8'h3C at select, then 8'hC3 before the first byte boundary, clock two bytes -> MISO bits 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1, with txdata_ack pulsing at each of the 2 boundaries.
REQ-032 SHALL verify: 5 sclk pulses then deselect -> msg_end pulse, no rxdata_valid; next message byte 8'h0F -> rxdata = 8'h0F.
REQ-033 SHALL verify: sclk toggling while ssel_n high -> no pulses on any output, esp_miso = 0.
REQ-034 SHALL verify: reset asserted after bit 4 of a byte and released while ssel_n still low -> outputs 0, no rxdata_valid until reselect.
REQ-035 SHALL verify: sclk at clk/8 with 3-byte burst 8'h20, 8'h00, 8'h80 -> three rxdata_valid pulses with values in order, each SYNC_STAGES+1 cycles after the 8th rising pin edge.
